// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM states, BCD digit type, digit moduli and tmp field offsets
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_e;
  typedef logic [3:0] bcd_t;
  localparam int N_DIG = 8;
  // Digit 0 is centisecond units, digit 7 is hour tens.
  localparam int DIG_MOD [N_DIG] = '{10, 10, 10, 6, 10, 6, 10, 10};
  localparam int OFS_CC = 0;
  localparam int OFS_SS = 8;
  localparam int OFS_MM = 16;
  localparam int OFS_HH = 24;
endpackage

// File: rtl/bcd_cnt.sv
// bcd_cnt: one BCD digit counting 0..MOD-1 with a same-cycle ripple carry out
module bcd_cnt
  import stopwatch_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);
  bcd_t digit_q, digit_d;
  always_comb begin
    carry = inc && digit_q == 4'(MOD - 1);
    digit_d = clr || carry ? '0 : inc ? digit_q + 4'd1 : digit_q;
  end
  always_ff @(posedge clk) begin
    if (rst) digit_q <= '0;
    else digit_q <= digit_d;
  end
  assign digit = digit_q;
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: HH:MM:SS.cc BCD stopwatch with run/pause/clear; lap freeze built only with STOPWATCH_LAP_EN
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIV = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic [31:0] tmp,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);
  state_e state_q, state_d;
  logic ss_q, cl_q, ss_e, cl_e, clr_acc, run, tick, ovf_q, ovf_d;
  logic [23:0] psc_q, psc_d;
  logic [31:0] cnt, tmp_q, tmp_d;
  logic [N_DIG:0] inc;
`ifdef STOPWATCH_LAP_EN
  logic lp_q, lp_e;
  always_ff @(posedge clk) begin
    if (rst) lp_q <= 1'b0;
    else lp_q <= lap;
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
`endif
  // Ignored clear is not an event, so start_stop still acts in RUN/LAP.
  always_comb begin
    ss_e = start_stop & ~ss_q;
    cl_e = clear & ~cl_q;
    run = state_q == RUN || state_q == LAP;
    clr_acc = cl_e && !run;
    state_d = clr_acc ? IDLE : ss_e ? (run ? PAUSE : RUN) : state_q;
`ifdef STOPWATCH_LAP_EN
    lp_e = lap & ~lp_q;
    if (!clr_acc && !ss_e && lp_e)
      state_d = state_q == RUN ? LAP : state_q == LAP ? RUN : state_q;
    tmp_d = state_q == LAP ? tmp_q : cnt;
`else
    tmp_d = cnt;
`endif
    tick = run && psc_q == 24'(DIV - 1);
    psc_d = state_q == IDLE || clr_acc || tick ? '0 : run ? psc_q + 24'd1 : psc_q;
    ovf_d = !clr_acc && (ovf_q || inc[N_DIG]);
  end
  assign inc[0] = tick;
  for (genvar i = 0; i < N_DIG; i++) begin : g_dig
    bcd_cnt #(.MOD(DIG_MOD[i])) u_cnt (
      .clk,
      .rst,
      .clr  (clr_acc),
      .inc  (inc[i]),
      .digit(cnt[4*i+:4]),
      .carry(inc[i+1])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ss_q <= 1'b0;
      cl_q <= 1'b0;
      psc_q <= '0;
      ovf_q <= 1'b0;
      tmp_q <= '0;
    end else begin
      state_q <= state_d;
      ss_q <= start_stop;
      cl_q <= clear;
      psc_q <= psc_d;
      ovf_q <= ovf_d;
      tmp_q <= tmp_d;
    end
  end
  assign tmp = tmp_q;
  assign running = run;
  assign overflow = ovf_q;
`ifdef STOPWATCH_LAP_EN
  assign lap_active = state_q == LAP;
`else
  assign lap_active = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed stimulus pushes expected outputs; a negedge monitor pops and compares
module tb_stopwatch_core;
  logic clk = 1'b0, rst = 1'b1, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [31:0] tmp;
  logic running, lap_active, overflow;
  typedef struct {
    string       name;
    logic [31:0] tmp;
    logic        run;
    logic        lap;
    logic        ovf;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0;

  stopwatch_core #(.DIV(4)) dut (
    .clk, .rst, .start_stop, .lap, .clear, .tmp, .running, .lap_active, .overflow
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic [31:0] t, input logic r, input logic l, input logic o);
    exp_t e;
    e.name = nm; e.tmp = t; e.run = r; e.lap = l; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic press_ss();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic press_lap();
    lap = 1'b1;
    step(1);
    lap = 1'b0;
  endtask

  task automatic press_clr();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        n_chk++;
        if (tmp === e.tmp && running === e.run && lap_active === e.lap && overflow === e.ovf) n_pass++;
        else $display("FAIL %s: got tmp=%h run=%b lap=%b ovf=%b, want tmp=%h run=%b lap=%b ovf=%b",
                      e.name, tmp, running, lap_active, overflow, e.tmp, e.run, e.lap, e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d checks done", n_chk);
    $fatal(1);
  end

  initial begin
    step(2);
    push("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    press_ss();
    push("run_start", 32'h0, 1'b1, 1'b0, 1'b0);
    step(41);
    push("run_40", 32'h0000_0010, 1'b1, 1'b0, 1'b0);
    press_ss();
    push("pause", 32'h0000_0010, 1'b0, 1'b0, 1'b0);
    step(20);
    push("pause_hold", 32'h0000_0010, 1'b0, 1'b0, 1'b0);
    press_clr();
    push("clear_lag", 32'h0000_0010, 1'b0, 1'b0, 1'b0);
    step(1);
    push("clear", 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef STOPWATCH_LAP_EN
    press_ss();
    step(21);
    press_lap();
    push("lap_freeze", 32'h0000_0005, 1'b1, 1'b1, 1'b0);
    step(40);
    push("lap_hold", 32'h0000_0005, 1'b1, 1'b1, 1'b0);
    press_lap();
    push("lap_exit", 32'h0000_0005, 1'b1, 1'b0, 1'b0);
    step(1);
    push("lap_resume", 32'h0000_0015, 1'b1, 1'b0, 1'b0);
    press_lap();
    push("lap_again", 32'h0000_0016, 1'b1, 1'b1, 1'b0);
    press_ss();
    push("lap_to_pause", 32'h0000_0016, 1'b0, 1'b0, 1'b0);
    press_ss();
    press_lap();
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    push("rst_lap", 32'h0, 1'b0, 1'b0, 1'b0);
`else
    press_ss();
    press_lap();
    push("lap_ignored", 32'h0, 1'b1, 1'b0, 1'b0);
    step(4);
    press_lap();
    push("lap_ignored2", 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    push("rst_run", 32'h0, 1'b0, 1'b0, 1'b0);
`endif
    press_ss();
    step(1);
    press_ss();
    force dut.g_dig[0].u_cnt.digit_q = 4'd9;
    force dut.g_dig[1].u_cnt.digit_q = 4'd9;
    force dut.g_dig[2].u_cnt.digit_q = 4'd9;
    force dut.g_dig[3].u_cnt.digit_q = 4'd5;
    force dut.g_dig[4].u_cnt.digit_q = 4'd9;
    force dut.g_dig[5].u_cnt.digit_q = 4'd5;
    force dut.g_dig[6].u_cnt.digit_q = 4'd9;
    force dut.g_dig[7].u_cnt.digit_q = 4'd9;
    #1;
    release dut.g_dig[0].u_cnt.digit_q;
    release dut.g_dig[1].u_cnt.digit_q;
    release dut.g_dig[2].u_cnt.digit_q;
    release dut.g_dig[3].u_cnt.digit_q;
    release dut.g_dig[4].u_cnt.digit_q;
    release dut.g_dig[5].u_cnt.digit_q;
    release dut.g_dig[6].u_cnt.digit_q;
    release dut.g_dig[7].u_cnt.digit_q;
    step(1);
    push("preload", 32'h9959_5999, 1'b0, 1'b0, 1'b0);
    press_ss();
    step(3);
    push("wrap", 32'h0, 1'b1, 1'b0, 1'b1);
    press_ss();
    push("ovf_sticky", 32'h0, 1'b0, 1'b0, 1'b1);
    press_clr();
    push("ovf_cleared", 32'h0, 1'b0, 1'b0, 1'b0);
    press_ss();
    step(9);
    press_ss();
    step(1);
    push("pause2", 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    clear = 1'b1;
    start_stop = 1'b1;
    step(1);
    clear = 1'b0;
    start_stop = 1'b0;
    push("clr_ss_a", 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    step(1);
    push("clr_ss_b", 32'h0, 1'b0, 1'b0, 1'b0);
    press_ss();
    step(5);
    push("restart", 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    press_clr();
    push("clr_in_run", 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    step(3);
    push("run_after_clr", 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    if (sb.size() != 0) $display("FAIL scoreboard: %0d expectations never checked", sb.size());
    if (n_chk < 12) $display("FAIL count: only %0d checks done", n_chk);
    if (n_pass != n_chk) $display("FAIL summary: %0d of %0d checks failed", n_chk - n_pass, n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
